// File: rtl/hann_pkg.sv
// Shared constants for the Hann windowing stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hann_pkg;

  // Default geometry: 1024-point frames, 16-bit signed samples, Q0.16 coefficients.
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int COEF_WIDTH_DEF = 16;

  // Width of the sign-extended sample times zero-extended coefficient.
  function automatic int prod_width(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  localparam int PROD_WIDTH = prod_width(DATA_WIDTH_DEF, COEF_WIDTH_DEF);

  // Half an LSB of the Q0.16 result, added before the shift to round half up.
  localparam int RND = 1 << 15;

endpackage

// File: rtl/hann_mul_rnd.sv
// Signed sample x unsigned Q0.COEF_WIDTH coefficient, rounded half up back to DATA_WIDTH.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module hann_mul_rnd
  import hann_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int PROD_W     = PROD_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic        [COEF_WIDTH-1:0] coef,
  output logic        [DATA_WIDTH-1:0] result
);

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rnd_sum;
  logic                     unused_bits;

  // Multiply in a width that holds the full signed product, then round and drop the
  // fractional bits. With coef <= 0xFFFF the magnitude never exceeds the sample's, so
  // taking DATA_WIDTH bits above the binary point is the arithmetic shift, no saturation.
  always_comb begin
    sample_ext = {{(PROD_W-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
    coef_ext   = {{(PROD_W-COEF_WIDTH){1'b0}}, coef};
    prod       = sample_ext * coef_ext;
    rnd_sum    = prod + PROD_W'(RND);
    result     = rnd_sum[COEF_WIDTH +: DATA_WIDTH];
  end

  // Fraction bits and the redundant top sign bit are discarded by design.
  assign unused_bits = ^{rnd_sum[COEF_WIDTH-1:0], rnd_sum[PROD_W-1 -: (PROD_W-COEF_WIDTH-DATA_WIDTH)]};

endmodule

// File: rtl/hann_window_mult.sv
// Hann windowing stage: indexes samples within a frame, fetches coef from external ROM, multiplies/rounds.
// Latency: sample accepted at edge N appears on m_data after edge N+1 (ROM read overlaps stage 1).
// Backpressure: single enable; while m_valid && !m_ready everything holds and s_ready is low.
module hann_window_mult
  import hann_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COEF_WIDTH = COEF_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_first,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [COEF_WIDTH-1:0] lut_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_first,
  output logic                  m_last,
  output logic [15:0]           frame_cnt
);

  logic                  en;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] used_idx;
  logic [DATA_WIDTH-1:0] mul_y;

  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [ADDR_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_first_q, m_first_d;
  logic                  m_last_q, m_last_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  // Handshake and ROM address; the address is chosen so the ROM output always matches s1_idx.
  always_comb begin
    en       = !m_valid_q || m_ready;
    accept   = s_valid && en;
    used_idx = s_first ? '0 : idx_q;
    lut_addr = accept ? used_idx : s1_idx_q;
  end

  hann_mul_rnd #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .PROD_W     (prod_width(DATA_WIDTH, COEF_WIDTH))
  ) u_mul (
    .sample (s1_data_q),
    .coef   (lut_data),
    .result (mul_y)
  );

  // Next-state: index counter, stage 1 capture, stage 2 multiply output, completed-frame count.
  always_comb begin
    idx_d       = idx_q;
    s1_data_d   = s1_data_q;
    s1_idx_d    = s1_idx_q;
    s1_valid_d  = s1_valid_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_first_d   = m_first_q;
    m_last_d    = m_last_q;
    frame_cnt_d = frame_cnt_q;

    if (accept) begin
      idx_d      = used_idx + 1'b1;
      s1_data_d  = s_data;
      s1_idx_d   = used_idx;
      s1_valid_d = 1'b1;
    end else if (en) begin
      s1_valid_d = 1'b0;
    end

    if (en) begin
      m_valid_d = s1_valid_q;
      m_data_d  = mul_y;
      m_first_d = (s1_idx_q == '0);
      m_last_d  = (s1_idx_q == {ADDR_WIDTH{1'b1}});
    end

    // Only a delivered last sample closes a frame; a realigned partial frame never counts.
    if (m_valid_q && m_ready && m_last_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      idx_q       <= '0;
      s1_data_q   <= '0;
      s1_idx_q    <= '0;
      s1_valid_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_first_q   <= 1'b0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      idx_q       <= idx_d;
      s1_data_q   <= s1_data_d;
      s1_idx_q    <= s1_idx_d;
      s1_valid_q  <= s1_valid_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_first_q   <= m_first_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_ready   = en;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_first   = m_first_q;
  assign m_last    = m_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hann_window_mult.sv
// Bench for hann_window_mult: ROM model, queue-based reference model, directed vectors.
// Latency: n/a.
// Backpressure: m_ready is driven by the bench to exercise stalls.
module tb_hann_window_mult;

  logic        clk = 1'b0;
  logic        tb_rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_first;
  logic [9:0]  lut_addr;
  logic [15:0] lut_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_first;
  logic        m_last;
  logic [15:0] frame_cnt;

  hann_window_mult dut (
    .clk       (clk),
    .tb_rst    (tb_rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_first   (s_first),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_first   (m_first),
    .m_last    (m_last),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM contents: a ramp (coef[k] = k*64) or a raised window peaking at 0xFFFF.
  logic use_win = 1'b0;

  function automatic logic [15:0] coef_of(input int k);
    longint v;
    if (use_win) v = (longint'(k) * longint'(1023 - k) * 65535) / 261632;
    else         v = longint'(k) * 64;
    return v[15:0];
  endfunction

  // 1-cycle read latency, no output register.
  always @(posedge clk) lut_data <= coef_of(int'(lut_addr));

  // Reference arithmetic: round-half-up of sample*coef/65536.
  function automatic logic [15:0] win_out(input logic [15:0] d, input logic [15:0] c);
    longint p;
    p = longint'($signed(d)) * longint'(c);
    p = (p + 32768) >>> 16;
    return p[15:0];
  endfunction

  typedef struct {
    logic [15:0] d;
    logic        f;
    logic        l;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          used;
  int          m_idx = 0;
  int          m_frames = 0;
  int          stall_n = 0;
  int          n_first = 0;
  int          n_last = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] p_data, p_lut;
  logic        p_first, p_last;

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (tb_rst) begin
      q.delete();
      m_idx      = 0;
      m_frames   = 0;
      prev_stall = 1'b0;
    end else begin
      chk("frame_cnt", frame_cnt, m_frames);
      chk("s_ready", s_ready, !(m_valid && !m_ready));
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, p_data);
        chk("hold_first", m_first, p_first);
        chk("hold_last", m_last, p_last);
        chk("hold_lut", lut_data, p_lut);
      end
      if (m_valid && !m_ready) stall_n++;
      if (s_valid && s_ready) begin
        used  = s_first ? 0 : m_idx;
        e.d   = win_out(s_data, coef_of(used));
        e.f   = (used == 0);
        e.l   = (used == 1023);
        q.push_back(e);
        m_idx = (used + 1) % 1024;
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_first", m_first, e.f);
          chk("m_last", m_last, e.l);
          if (m_first) n_first++;
          if (m_last) n_last++;
          if (e.l) m_frames = (m_frames + 1) & 16'hFFFF;
        end
      end
      prev_stall = m_valid && !m_ready;
      p_data  = m_data;
      p_first = m_first;
      p_last  = m_last;
      p_lut   = lut_data;
    end
  end

  // Present one sample until it is accepted; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic f);
    int   budget;
    logic acc;
    budget  = 0;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 50) begin
        chk("send_timeout", budget, 0);
        acc = 1'b1;
      end
    end
    s_first = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_first = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stream zeros up to idx, then d at idx; check the output one edge after acceptance.
  task automatic directed(input logic [15:0] d, input int idx, input logic [15:0] exp, input string name);
    send(16'h0000, 1'b1);
    for (int k = 1; k < idx; k++) send(16'h0000, 1'b0);
    send(d, 1'b0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_valid"}, m_valid, 1);
    chk(name, m_data, exp);
    chk({name, "_last"}, m_last, (idx == 1023));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_first"}, m_first, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_s_ready"}, s_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    tb_rst  = 1'b1;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    s_first = 1'b0;
    m_ready = 1'b1;
    #12;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    idle(1);

    // Directed products on the ramp ROM (coef[512] = 0x8000, coef[1023] = 0xFFC0).
    directed(16'h4000, 512, 16'h2000, "mul_half");
    idle(2);
    directed(16'h0001, 512, 16'h0001, "rnd_half_up");
    idle(2);
    directed(16'hFFFF, 512, 16'h0000, "rnd_neg_one");
    idle(2);
    chk("frame_cnt_partial", frame_cnt, 0);
    // -32768 * 65472 / 65536 = -32736 exactly.
    directed(16'h8000, 1023, 16'h8020, "mul_min");
    idle(2);
    chk("frame_cnt_after_last", frame_cnt, 1);
    chk("queue_drained_directed", q.size(), 0);

    // Realign at idx 300: the aborted frame never closes.
    send(16'h1234, 1'b1);
    for (int k = 1; k < 300; k++) send(16'(k * 7), 1'b0);
    send(16'h7FFF, 1'b1);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("realign_valid", m_valid, 1);
    chk("realign_first", m_first, 1);
    chk("realign_data", m_data, 0);
    for (int k = 1; k < 6; k++) send(16'(16'h2000 + k), 1'b0);
    idle(3);
    chk("realign_frame_cnt", frame_cnt, 1);
    chk("queue_drained_realign", q.size(), 0);

    // Backpressure: 5 cycles of m_ready low while the source keeps offering data.
    stall_n = 0;
    send(16'h0100, 1'b1);
    fork
      begin
        for (int k = 1; k < 40; k++) send(16'(16'h0100 + k * 37), 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    idle(3);
    chk("stall_cycles", stall_n, 5);
    chk("queue_drained_stall", q.size(), 0);

    // Reset mid-frame: outputs clear at once, numbering restarts without s_first.
    send(16'h5555, 1'b1);
    for (int k = 1; k < 20; k++) send(16'(16'h4000 - k), 1'b0);
    s_valid = 1'b0;
    tb_rst  = 1'b1;
    #1;
    check_reset_values("midrst");
    repeat (3) @(posedge clk);
    #1;
    tb_rst = 1'b0;
    idle(1);
    send(16'h7FFF, 1'b0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", m_valid, 1);
    chk("post_rst_first", m_first, 1);
    chk("post_rst_frame_cnt", frame_cnt, 0);
    idle(2);

    // Full frame on the window ROM with full-scale positive samples.
    use_win = 1'b1;
    idle(2);
    n_first = 0;
    n_last  = 0;
    for (int k = 0; k < 1024; k++) send(16'h7FFF, (k == 0));
    idle(3);
    chk("frame_first_count", n_first, 1);
    chk("frame_last_count", n_last, 1);
    chk("frame_cnt_full", frame_cnt, 1);
    chk("queue_drained_frame", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
